pwm_tick_counter: RTL and testbench

//  Free-running modulo-(max_count+1) tick generator; emits a 1-cycle terminal-count pulse.

---
 rtl/pwm_tick_counter_if.sv | 19 +
 rtl/pwm_tick_counter.sv | 35 +++
 tb/tb_pwm_tick_counter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pwm_tick_counter_if.sv
// Control/status bundle for pwm_tick_counter.
// The count observation port exists only when COUNTER_COUNT_OUT_EN is defined.
interface pwm_tick_counter_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             enable;
   logic [WIDTH-1:0] max_count;
   logic             tc;
`ifdef COUNTER_COUNT_OUT_EN
   logic [WIDTH-1:0] count;

   modport slave  (input clr, enable, max_count, output tc, count);
   modport master (output clr, enable, max_count, input tc, count);
`else
   modport slave  (input clr, enable, max_count, output tc);
   modport master (output clr, enable, max_count, input tc);
`endif
endinterface

// File: rtl/pwm_tick_counter.sv
// Free-running modulo-(max_count+1) tick generator with a combinational terminal-count pulse.
// Optional feature macro: COUNTER_COUNT_OUT_EN exposes the counter register on bus.count.
module pwm_tick_counter #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   pwm_tick_counter_if.slave   bus
);

   logic [WIDTH-1:0] cnt_q;
   logic             at_term;

   // Unsigned >= so a max_count lowered below the current count still terminates and wraps.
   assign at_term = (cnt_q >= bus.max_count);

   // Gated by rst so tc is low the instant reset asserts, even when max_count is 0.
   assign bus.tc = rst & bus.enable & ~bus.clr & at_term;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (bus.clr) begin
         cnt_q <= '0;
      end else if (bus.enable) begin
         if (at_term) cnt_q <= '0;
         else         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

`ifdef COUNTER_COUNT_OUT_EN
   assign bus.count = cnt_q;
`endif

endmodule

// File: tb/tb_pwm_tick_counter.sv
// Directed bench for pwm_tick_counter: a driver pushes hand-computed {tc,count} into a queue,
// a monitor pops and compares shortly after each drive.
module tb_pwm_tick_counter;
   localparam int W = 8;

   logic clk;
   logic rst;
   pwm_tick_counter_if #(.WIDTH(W)) bus ();

   pwm_tick_counter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [W:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   event       drv_ev;
   string      cur_name = "reset";

   // Inputs change on the falling edge; tc is combinational so it is checked 1 ns later.
   task automatic step(input logic r, input logic c, input logic e, input logic [W-1:0] m,
                       input logic exp_tc, input logic [W-1:0] exp_cnt);
      @(negedge clk);
      rst           = r;
      bus.clr       = c;
      bus.enable    = e;
      bus.max_count = m;
      exp_q.push_back({exp_tc, exp_cnt});
      -> drv_ev;
   endtask

   // monitor
   always begin
      @(drv_ev);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got output with empty queue, required a queued expectation", cur_name);
      end else begin
         logic [W:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (bus.tc !== e[W]) begin
            n_fail++;
            $display("FAIL %s tc @%0t: got %b, required %b", cur_name, $time, bus.tc, e[W]);
         end
`ifdef COUNTER_COUNT_OUT_EN
         n_checks++;
         if (bus.count !== e[W-1:0]) begin
            n_fail++;
            $display("FAIL %s count @%0t: got %0d, required %0d", cur_name, $time, bus.count, e[W-1:0]);
         end
`endif
      end
   end

   initial begin
      rst           = 1'b0;
      bus.clr       = 1'b0;
      bus.enable    = 1'b0;
      bus.max_count = '0;

      // reset state: enable=1, max=0 would give tc=1 if reset did not gate it
      cur_name = "reset";
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);

      // max=3: tc every 4th cycle
      cur_name = "max3";
      for (int i = 0; i < 8; i++) step(1, 0, 1, 3, (i % 4) == 3, W'(i % 4));

      // max=0: tc every cycle, count stuck at 0
      cur_name = "max0";
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 0);

      // max=5 with enable toggling; count holds while disabled
      cur_name = "enable_toggle";
      step(1, 0, 1, 5, 0, 0);
      step(1, 0, 0, 5, 0, 1);
      step(1, 0, 1, 5, 0, 1);
      step(1, 0, 0, 5, 0, 2);
      step(1, 0, 1, 5, 0, 2);
      step(1, 0, 1, 5, 0, 3);
      step(1, 0, 0, 5, 0, 4);
      step(1, 0, 1, 5, 0, 4);
      step(1, 0, 1, 5, 1, 5);
      step(1, 0, 0, 5, 0, 0);
      step(1, 0, 1, 5, 0, 0);

      // advance to count=4, then clear; next tc 6 enabled cycles later
      cur_name = "clr_at4";
      step(1, 0, 1, 5, 0, 1);
      step(1, 0, 1, 5, 0, 2);
      step(1, 0, 1, 5, 0, 3);
      step(1, 1, 1, 5, 0, 4);
      for (int i = 0; i < 6; i++) step(1, 0, 1, 5, i == 5, W'(i));

      // clr at terminal count suppresses tc and restarts from 0
      cur_name = "clr_at_tc";
      for (int i = 0; i < 5; i++) step(1, 0, 1, 5, 0, W'(i));
      step(1, 1, 1, 5, 0, 5);
      step(1, 0, 1, 5, 0, 0);

      // count=10, max lowered to 3: tc immediately, then wrap
      cur_name = "max_lowered";
      for (int i = 1; i < 10; i++) step(1, 0, 1, 20, 0, W'(i));
      step(1, 0, 1, 3, 1, 10);
      step(1, 0, 1, 3, 0, 0);

      // full-range period: max=255 walks every value, wraps once
      cur_name = "max255";
      for (int i = 1; i < 256; i++) step(1, 0, 1, 8'hFF, i == 255, W'(i));
      step(1, 0, 1, 8'hFF, 0, 0);

      // async reset mid-count at 7, no clock edge before the check
      cur_name = "async_rst";
      for (int i = 1; i < 7; i++) step(1, 0, 1, 20, 0, W'(i));
      step(0, 0, 1, 0, 0, 0);
      cur_name = "after_rst";
      for (int i = 0; i < 8; i++) step(1, 0, 1, 3, (i % 4) == 3, W'(i % 4));

      // final report
      @(negedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
